// File: rtl/maze_solver_ctrl.sv
// Depth-first maze search controller for a 16x16 wall/free bit-memory.
// Performs one maze access per cycle, marks visited cells in the maze itself,
// keeps the move history on a direction stack, and streams the found path
// over a valid/ready handshake.
module maze_solver_ctrl #(
  parameter int unsigned SX    = 0,
  parameter int unsigned SY    = 0,
  parameter int unsigned TX    = 15,
  parameter int unsigned TY    = 15,
  parameter int unsigned DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_din,
  output logic [3:0] mem_x,
  output logic [3:0] mem_y,
  input  logic       mem_dout,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] path_len,
  output logic       path_valid,
  output logic [1:0] path_dir,
  input  logic       path_ready
);

  localparam int unsigned SpW = $clog2(DEPTH);
  localparam logic [SpW-1:0] SpOne = SpW'(1);
  localparam logic [3:0] StartX = SX[3:0];
  localparam logic [3:0] StartY = SY[3:0];
  localparam logic [3:0] TgtX   = TX[3:0];
  localparam logic [3:0] TgtY   = TY[3:0];

  typedef enum logic [2:0] {
    StIdle, StChk, StMark, StProbe, StBack, StSuccess, StFail
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cur_x_q, cur_x_d;
  logic [3:0]     cur_y_q, cur_y_d;
  logic [1:0]     dir_q, dir_d;
  logic [SpW-1:0] sp_q, sp_d;
  logic [SpW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]     stack_q [DEPTH];
  logic           push;

  logic [3:0] nb_x, nb_y;
  logic       nb_ok;
  logic [1:0] top_dir;
  logic [3:0] bk_x, bk_y;
  logic       xfer;

  assign top_dir = stack_q[sp_q - SpOne];
  assign xfer    = path_valid & path_ready;

  // Neighbour of cur in the probe direction; bounds checked before the add/subtract.
  always_comb begin
    nb_x  = cur_x_q;
    nb_y  = cur_y_q;
    nb_ok = 1'b0;
    unique case (dir_q)
      2'd0: begin nb_ok = (cur_x_q != 4'd0);  nb_x = cur_x_q - 4'd1; end
      2'd1: begin nb_ok = (cur_y_q != 4'd15); nb_y = cur_y_q + 4'd1; end
      2'd2: begin nb_ok = (cur_x_q != 4'd15); nb_x = cur_x_q + 4'd1; end
      default: begin nb_ok = (cur_y_q != 4'd0); nb_y = cur_y_q - 4'd1; end
    endcase
  end

  // Backtrack step: undo the popped move (opposite direction = p xor 2).
  always_comb begin
    bk_x = cur_x_q;
    bk_y = cur_y_q;
    unique case (top_dir ^ 2'd2)
      2'd0:    bk_x = cur_x_q - 4'd1;
      2'd1:    bk_y = cur_y_q + 4'd1;
      2'd2:    bk_x = cur_x_q + 4'd1;
      default: bk_y = cur_y_q - 4'd1;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cur_x_q  <= 4'd0;
      cur_y_q  <= 4'd0;
      dir_q    <= 2'd0;
      sp_q     <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      dir_q    <= dir_d;
      sp_q     <= sp_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Direction stack storage; contents need no reset since sp bounds all reads.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q] <= dir_q;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    dir_d    = dir_q;
    sp_d     = sp_q;
    rd_ptr_d = rd_ptr_q;
    push     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StChk;
          cur_x_d = StartX;
          cur_y_d = StartY;
          sp_d    = '0;
        end
      end
      StChk: state_d = mem_dout ? StFail : StMark;
      StMark: begin
        if (cur_x_q == TgtX && cur_y_q == TgtY) begin
          state_d  = StSuccess;
          rd_ptr_d = '0;
        end else begin
          state_d = StProbe;
          dir_d   = 2'd0;
        end
      end
      StProbe: begin
        if (nb_ok && !mem_dout) begin
          push    = 1'b1;
          sp_d    = sp_q + SpOne;
          cur_x_d = nb_x;
          cur_y_d = nb_y;
          state_d = StMark;
        end else if (dir_q != 2'd3) begin
          dir_d = dir_q + 2'd1;
        end else begin
          state_d = StBack;
        end
      end
      StBack: begin
        if (sp_q == '0) begin
          state_d = StFail;
        end else begin
          sp_d    = sp_q - SpOne;
          cur_x_d = bk_x;
          cur_y_d = bk_y;
          // A popped W move exhausted that cell, so keep unwinding.
          if (top_dir != 2'd3) begin
            dir_d   = top_dir + 2'd1;
            state_d = StProbe;
          end
        end
      end
      StSuccess, StFail: begin
        if (start) begin
          state_d  = StChk;
          cur_x_d  = StartX;
          cur_y_d  = StartY;
          sp_d     = '0;
          rd_ptr_d = '0;
        end else if (state_q == StSuccess && xfer) begin
          rd_ptr_d = rd_ptr_q + SpOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state; memory port is quiet unless accessing.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_din    = 1'b0;
    mem_x      = 4'd0;
    mem_y      = 4'd0;
    busy       = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    path_len   = 8'd0;
    path_valid = 1'b0;
    path_dir   = 2'd0;
    unique case (state_q)
      StChk: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        mem_x  = cur_x_q;
        mem_y  = cur_y_q;
      end
      StMark: begin
        busy    = 1'b1;
        mem_wr  = 1'b1;
        mem_din = 1'b1;
        mem_x   = cur_x_q;
        mem_y   = cur_y_q;
      end
      StProbe: begin
        busy = 1'b1;
        if (nb_ok) begin
          mem_rd = 1'b1;
          mem_x  = nb_x;
          mem_y  = nb_y;
        end
      end
      StBack: busy = 1'b1;
      StSuccess: begin
        done       = 1'b1;
        path_len   = 8'(sp_q);
        path_valid = (rd_ptr_q < sp_q);
        path_dir   = stack_q[rd_ptr_q];
      end
      StFail: fail = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Scoreboard bench for maze_solver_ctrl: a behavioural DFS model predicts the
// path and final maze marks; a monitor checks the streamed path.
module tb_maze_solver_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mem_rd, mem_wr, mem_din;
  logic [3:0] mem_x, mem_y;
  logic       mem_dout;
  logic       busy, done, fail;
  logic [7:0] path_len;
  logic       path_valid;
  logic [1:0] path_dir;
  logic       path_ready = 1'b1;

  maze_solver_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_din    (mem_din),
    .mem_x      (mem_x),
    .mem_y      (mem_y),
    .mem_dout   (mem_dout),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .path_len   (path_len),
    .path_valid (path_valid),
    .path_dir   (path_dir),
    .path_ready (path_ready)
  );

  always #5 clk = ~clk;

  bit maze [16][16];
  bit mm   [16][16];
  int exp_dirs [$];
  int exp_q [$];
  bit exp_ok;

  int n_vec = 0;
  int n_fail = 0;
  int rmode = 0;
  int rcnt = 0;
  int wr_cnt = 0;
  int busy_run = 0;
  int busy_max = 0;
  bit prev_stall = 0;
  logic [1:0] prev_dir = 2'd0;

  assign mem_dout = mem_rd ? maze[mem_x][mem_y] : 1'b0;

  // Maze memory: synchronous write.
  always @(posedge clk) if (mem_wr) maze[mem_x][mem_y] = mem_din;

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Consumer ready pattern generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: path_ready = 1'b1;
        1: path_ready = (rcnt >= 2) && (rcnt % 2 == 0);
        default: path_ready = 1'($urandom_range(0, 1));
      endcase
      rcnt++;
    end
  end

  // Monitor: path stream scoreboard plus port-level invariants.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      busy_run = 0;
    end else begin
      if (mem_rd || mem_wr) check("rd_wr_exclusive", int'(mem_rd & mem_wr), 0);
      if (mem_wr) wr_cnt++;
      if (busy) busy_run++; else busy_run = 0;
      if (busy_run > busy_max) busy_max = busy_run;
      if (prev_stall) begin
        check("stall_valid_held", int'(path_valid), 1);
        check("stall_dir_stable", int'(path_dir), int'(prev_dir));
      end
      if (path_valid && path_ready) begin
        check("xfer_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("path_dir", int'(path_dir), exp_q.pop_front());
      end
      prev_stall = path_valid && !path_ready;
      prev_dir = path_dir;
    end
  end

  // Reference: plain DFS over the grid, neighbours tried N,E,S,W, cells marked on entry.
  task automatic model_run();
    int cx [$];
    int cy [$];
    int nd [$];
    int k, d, nx, ny;
    exp_dirs.delete();
    exp_ok = 1'b0;
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) mm[i][j] = maze[i][j];
    if (mm[0][0]) return;
    mm[0][0] = 1'b1;
    cx.push_back(0); cy.push_back(0); nd.push_back(0);
    while (cx.size() > 0) begin
      k = cx.size() - 1;
      if (nd[k] == 4) begin
        void'(cx.pop_back()); void'(cy.pop_back()); void'(nd.pop_back());
        if (exp_dirs.size() > 0) void'(exp_dirs.pop_back());
        continue;
      end
      d = nd[k];
      nd[k] = d + 1;
      nx = cx[k] + ((d == 2) ? 1 : 0) - ((d == 0) ? 1 : 0);
      ny = cy[k] + ((d == 1) ? 1 : 0) - ((d == 3) ? 1 : 0);
      if (nx < 0 || nx > 15 || ny < 0 || ny > 15) continue;
      if (mm[nx][ny]) continue;
      mm[nx][ny] = 1'b1;
      exp_dirs.push_back(d);
      cx.push_back(nx); cy.push_back(ny); nd.push_back(0);
      if (nx == 15 && ny == 15) begin
        exp_ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic load_zero();
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) maze[i][j] = 1'b0;
  endtask

  task automatic load_random(input int pct);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) maze[i][j] = ($urandom_range(0, 99) < pct);
    if ($urandom_range(0, 7) != 0) maze[0][0] = 1'b0;
    maze[15][15] = 1'b0;
  endtask

  // Runs one search; extra_at >= 0 pulses start again that many cycles in.
  task automatic run_search(input string tag, input int extra_at, output int cycles);
    int n, k, mism;
    model_run();
    foreach (exp_dirs[i]) exp_q.push_back(exp_dirs[i]);
    rcnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(done || fail) && n < 10000) begin
      if (n == extra_at) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n++;
    end
    cycles = n;
    check({tag, "_finished"}, int'(n < 10000), 1);
    check({tag, "_done"}, int'(done), int'(exp_ok));
    check({tag, "_fail"}, int'(fail), int'(!exp_ok));
    check({tag, "_path_len"}, int'(path_len), exp_ok ? exp_dirs.size() : 0);
    k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_stream_drained"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, "_valid_low_after"}, int'(path_valid), 0);
    check({tag, "_done_held"}, int'(done), int'(exp_ok));
    mism = 0;
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) if (maze[i][j] != mm[i][j]) mism++;
    check({tag, "_maze_marks"}, mism, 0);
  endtask

  initial begin
    int c1, c2, wr0, o;
    load_zero();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({busy, done, fail, path_valid, mem_rd, mem_wr, mem_din,
                                 path_len, mem_x, mem_y}), 0);
    rst_n = 1'b1;

    // Open maze: 15 E then 15 S.
    rmode = 0;
    run_search("open", -1, c1);
    check("open_len30", exp_dirs.size(), 30);

    // Same maze with backpressure.
    load_zero();
    rmode = 1;
    run_search("bp", -1, c2);

    // Walled start cell.
    load_zero();
    maze[0][0] = 1'b1;
    wr0 = wr_cnt;
    busy_max = 0;
    rmode = 0;
    run_search("wall_start", -1, c2);
    check("wall_start_by_cycle2", int'(c2 <= 2), 1);
    check("wall_start_no_write", wr_cnt - wr0, 0);
    check("wall_start_busy_max", int'(busy_max <= 1), 1);

    // Target sealed off: exhaustive search ending in fail.
    load_zero();
    maze[14][15] = 1'b1;
    maze[15][14] = 1'b1;
    run_search("sealed", -1, c2);

    // Reset mid-search.
    load_zero();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    o = int'({busy, done, fail, path_valid, mem_rd, mem_wr, mem_din, path_len, mem_x, mem_y});
    check("midrun_reset_outputs", o, 0);
    rst_n = 1'b1;
    exp_q.delete();
    load_zero();
    run_search("after_reset", -1, c2);
    check("after_reset_len", int'(path_len), 30);

    // Extra start while busy is ignored: same result and same cycle count.
    load_zero();
    run_search("double_start", 10, c2);
    check("double_start_cycles", c2, c1);

    // Random mazes with random backpressure.
    rmode = 2;
    for (int r = 0; r < 12; r++) begin
      load_random($urandom_range(15, 40));
      run_search($sformatf("rand%0d", r), -1, c2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
